// File: rtl/vlc_tx_arbiter.sv
// ---------------------------------------------------------------------------
// vlc_tx_arbiter
//
// Shares one byte-wide UART transmitter between NUM_REQ frame sources. A
// source is granted for a whole frame, round-robin. It keeps the transmitter
// until it presents a byte marked last, or until MAX_FRAME bytes have gone
// out. Each byte is handed to the UART with a one-cycle tx_start strobe. The
// arbiter then waits for tx_busy to rise and fall before it offers the next
// byte.
//
// Optional build macro: VLC_TX_ARB_WDOG_EN
//   Defined   : a watchdog counts cycles spent waiting on the UART handshake.
//               At WDOG_CYCLES-1 it pulses err_timeout and releases the grant.
//   Undefined : no watchdog logic; err_timeout is tied low and the handshake
//               waits indefinitely.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   req          in   [NUM_REQ]         per-source byte-ready request
//   req_data     in   [NUM_REQ*DATA_W]  source i byte at [i*DATA_W +: DATA_W]
//   req_last     in   [NUM_REQ]         presented byte ends its frame
//   req_ack      out  [NUM_REQ]         one-cycle pulse, byte consumed
//   grant        out  [NUM_REQ]         one-hot current owner, zero when idle
//   tx_data      out  [DATA_W]          byte to the UART transmitter
//   tx_start     out                    one-cycle start strobe to the UART
//   tx_busy      in                     UART busy flag
//   frame_done   out                    one-cycle pulse when a grant ends
//   err_timeout  out                    one-cycle watchdog error pulse
//
// All outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module vlc_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_FRAME   = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic                      frame_done,
  output logic                      err_timeout
);

  localparam int                 IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]         MAX_CNT  = 8'(MAX_FRAME);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Elaboration-time guard on the supported parameter ranges.
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (MAX_FRAME < 1) || (MAX_FRAME > 255) ||
      (WDOG_CYCLES < 2)) begin : g_bad_params
    $error("vlc_tx_arbiter: parameter out of supported range");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACC  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // (base + offs) mod NUM_REQ. offs is always below NUM_REQ, so one
  // conditional subtraction is enough.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int               offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Index of the source that follows idx in round-robin order.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Byte counter increments but holds at all-ones, so it never wraps.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  state_t              state_q,      state_d;
  logic [IDX_W-1:0]    sel_q,        sel_d;
  logic [IDX_W-1:0]    rr_ptr_q,     rr_ptr_d;
  logic [7:0]          byte_cnt_q,   byte_cnt_d;
  logic                last_q,       last_d;
  logic [NUM_REQ-1:0]  grant_q,      grant_d;
  logic [NUM_REQ-1:0]  req_ack_q,    req_ack_d;
  logic [DATA_W-1:0]   tx_data_q,    tx_data_d;
  logic                tx_start_q,   tx_start_d;
  logic                frame_done_q, frame_done_d;

  logic                do_release;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [DATA_W-1:0]   src_byte [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign src_byte[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Round-robin pick: the first requester at or after rr_ptr, with
  // wrap-around. rr_ptr always points one past the last released owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req[wrap_idx(rr_ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(rr_ptr_q, k);
      end
    end
  end

`ifdef VLC_TX_ARB_WDOG_EN
  localparam int              WDOG_W     = $clog2(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_timeout_q, err_timeout_d;
`endif

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    last_d       = last_q;
    grant_d      = grant_q;
    tx_data_d    = tx_data_q;
    req_ack_d    = '0;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    do_release   = 1'b0;
`ifdef VLC_TX_ARB_WDOG_EN
    wdog_d        = '0;
    err_timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d      = pick_idx;
          grant_d    = to_onehot(pick_idx);
          byte_cnt_d = '0;
          state_d    = SEND;
        end
      end

      SEND: begin
        // An owner that withdrew its request gives up the grant without
        // sending. Otherwise the byte goes out once the UART is free.
        if (!req[sel_q]) begin
          do_release = 1'b1;
        end else if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = src_byte[sel_q];
          req_ack_d  = to_onehot(sel_q);
          last_d     = req_last[sel_q];
          byte_cnt_d = sat_inc8(byte_cnt_q);
          state_d    = WAIT_ACC;
        end
      end

      WAIT_ACC: begin
        if (tx_busy) state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q || (byte_cnt_q == MAX_CNT)) begin
            do_release = 1'b1;
          end else if (req[sel_q]) begin
            state_d = SEND;
          end else begin
            do_release = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef VLC_TX_ARB_WDOG_EN
    // The counter runs only while the arbiter waits on the UART. Any state
    // change restarts it from zero. Expiry takes priority over the normal
    // handshake outcome.
    if ((state_q == WAIT_ACC) || (state_q == WAIT_DONE)) begin
      if (wdog_q == WDOG_LIMIT) begin
        err_timeout_d = 1'b1;
        do_release    = 1'b1;
      end else if (state_d == state_q) begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end
`endif

    // Normal end of frame, abort, and watchdog expiry all release the same
    // way.
    if (do_release) begin
      grant_d      = '0;
      frame_done_d = 1'b1;
      rr_ptr_d     = next_idx(sel_q);
      state_d      = IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      rr_ptr_q     <= '0;
      byte_cnt_q   <= '0;
      last_q       <= 1'b0;
      grant_q      <= '0;
      req_ack_q    <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      req_ack_q    <= req_ack_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef VLC_TX_ARB_WDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign grant      = grant_q;
  assign req_ack    = req_ack_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vlc_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vlc_tx_arbiter
//
// Directed bench for vlc_tx_arbiter. Source FIFOs and a UART TX busy model
// are stepped once per clock from the main sequence. Each expected
// transmitted byte, with its owning source, is queued when the stimulus is
// loaded. The queue is popped and compared on every tx_start.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vlc_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int MAX_FRAME   = 16;
  localparam int WDOG_CYCLES = 64;
  localparam int BUSY_LEN    = 5;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_last = '0;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_busy = 1'b0;
  logic                      frame_done;
  logic                      err_timeout;

  vlc_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .MAX_FRAME  (MAX_FRAME),
    .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ack    (req_ack),
    .grant      (grant),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .frame_done (frame_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         grant_log[$];
  logic [8:0] src_mem [NUM_REQ][64];
  int         src_rd [NUM_REQ];
  int         src_wr [NUM_REQ];
  int         ack_cnt [NUM_REQ];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0, fd_cyc = -1000;
  int err_cnt = 0, err_cyc = -1000;
  int fall_cyc = -1000, start_cyc = 0;
  int last_start_gap = 0, last_idle_gap = 0;
  int busy_cnt = 0;
  logic tx_mute = 1'b0;
  logic [NUM_REQ-1:0] prev_grant = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NUM_REQ-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic logic fifos_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (src_rd[i] != src_wr[i]) e = 1'b0;
    return e;
  endfunction

  task automatic load(input int s, input logic [7:0] d, input logic last);
    src_mem[s][src_wr[s] & 63] = {last, d};
    src_wr[s]++;
  endtask

  task automatic expect_tx(input int s, input logic [7:0] d);
    exp_t e;
    e.src  = 2'(s);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic monitor(input logic busy_seen);
    exp_t e;
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    if (tx_start) begin
      check("start_while_busy", 32'(busy_seen), 32'd0);
      check("ack_matches_grant", 32'(req_ack), 32'(grant));
      last_start_gap = cyc - fall_cyc;
      start_cyc      = cyc;
      check("start_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.data));
        check("tx_src", 32'(grant), 32'(1 << e.src));
      end
    end else if (req_ack != '0) begin
      check("ack_without_start", 32'(req_ack), 32'd0);
    end
    for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) ack_cnt[i]++;
    if (prev_grant == '0 && grant != '0) begin
      grant_log.push_back(oh_idx(grant));
      last_idle_gap = cyc - fd_cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
      check("grant_clear_on_done", 32'(grant), 32'd0);
    end
    if (err_timeout) begin
      err_cnt++;
      err_cyc = cyc;
    end
    prev_grant = grant;
  endtask

  task automatic tx_model();
    logic nb;
    if (rst) busy_cnt = 0;
    else if (tx_start && !tx_mute) busy_cnt = BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt--;
    nb = (busy_cnt != 0);
    if (tx_busy && !nb) fall_cyc = cyc;
    tx_busy = nb;
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ack[i] && (src_rd[i] != src_wr[i])) src_rd[i]++;
      if (src_rd[i] != src_wr[i]) begin
        req[i]                      = 1'b1;
        req_data[i*DATA_W +: DATA_W] = src_mem[i][src_rd[i] & 63][7:0];
        req_last[i]                 = src_mem[i][src_rd[i] & 63][8];
      end else begin
        req[i]                      = 1'b0;
        req_data[i*DATA_W +: DATA_W] = '0;
        req_last[i]                 = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic busy_seen;
    busy_seen = tx_busy;
    @(posedge clk);
    #1;
    cyc++;
    monitor(busy_seen);
    tx_model();
    drive_sources();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!((sb.size() == 0) && (grant == '0) && fifos_empty()) && (n < budget)) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n;
    n = 0;
    while (!tx_start && (n < budget)) begin
      tick();
      n++;
    end
    check(tag, 32'(tx_start), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    int fd0, ack0, n;
    int rr_exp [8];
    rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < NUM_REQ; i++) begin
      src_rd[i]  = 0;
      src_wr[i]  = 0;
      ack_cnt[i] = 0;
    end

    // Reset, then idle with no requests.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs", 32'({grant, req_ack, tx_start, tx_data, frame_done, err_timeout}), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_outputs", 32'({grant, req_ack, tx_start, tx_data, frame_done, err_timeout}), 32'd0);
    end

    // Source 1 sends a two-byte frame.
    ack0 = ack_cnt[1];
    fd0  = fd_cnt;
    load(1, 8'hA5, 1'b0);
    load(1, 8'h3C, 1'b1);
    expect_tx(1, 8'hA5);
    expect_tx(1, 8'h3C);
    drive_sources();
    tick();
    check("src1_grant", 32'(grant), 32'h2);
    tick();
    check("src1_first_start", 32'(tx_start), 32'd1);
    check("src1_first_ack", 32'(req_ack), 32'h2);
    n = 0;
    while ((fd_cnt == fd0) && (n < 60)) begin
      tick();
      n++;
    end
    check("src1_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("src1_byte_gap", 32'(last_start_gap), 32'd2);
    check("src1_done_after_fall", 32'(fd_cyc - fall_cyc), 32'd1);
    check("src1_grant_released", 32'(grant), 32'd0);
    check("src1_ack_count", 32'(ack_cnt[1] - ack0), 32'd2);
    wait_drain("src1_drain", 20);

    // Reset while the owner waits in WAIT_DONE.
    load(1, 8'h11, 1'b0);
    load(1, 8'h22, 1'b1);
    expect_tx(1, 8'h11);
    drive_sources();
    wait_start("rst_first_start", 10);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_start_ack", 32'({tx_start, req_ack}), 32'd0);
    src_rd[1] = src_wr[1];
    // rr_ptr was 2 before the reset; after reset source 0 must win over 3.
    load(0, 8'h55, 1'b1);
    load(3, 8'h77, 1'b1);
    expect_tx(0, 8'h55);
    expect_tx(3, 8'h77);
    drive_sources();
    tick();
    check("rst_then_idle_grant", 32'(grant), 32'h1);
    wait_drain("rst_drain", 60);

    // All four sources, two single-byte frames each.
    grant_log.delete();
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < NUM_REQ; s++) begin
        load(s, 8'(8'h40 + s * 16 + f), 1'b1);
        expect_tx(s, 8'(8'h40 + s * 16 + f));
      end
    end
    drive_sources();
    wait_drain("rr_drain", 300);
    check("rr_grant_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("rr_order", 32'((grant_log.size() > i) ? grant_log[i] : -1), 32'(rr_exp[i]));
    end
    check("rr_idle_gap", 32'(last_idle_gap), 32'd1);

    // Source 2 never marks last; source 3 waits its turn.
    grant_log.delete();
    fd0 = fd_cnt;
    for (int i = 0; i < 20; i++) load(2, 8'(8'h80 + i), 1'b0);
    load(3, 8'hC3, 1'b1);
    for (int i = 0; i < 16; i++) expect_tx(2, 8'(8'h80 + i));
    expect_tx(3, 8'hC3);
    for (int i = 16; i < 20; i++) expect_tx(2, 8'(8'h80 + i));
    drive_sources();
    wait_drain("max_drain", 500);
    check("max_frame_dones", 32'(fd_cnt - fd0), 32'd3);
    check("max_grant_count", 32'(grant_log.size()), 32'd3);
    check("max_owner0", 32'((grant_log.size() > 0) ? grant_log[0] : -1), 32'd2);
    check("max_owner1", 32'((grant_log.size() > 1) ? grant_log[1] : -1), 32'd3);
    check("max_owner2", 32'((grant_log.size() > 2) ? grant_log[2] : -1), 32'd2);

    // Source 0 stops requesting after three bytes without last.
    fd0  = fd_cnt;
    ack0 = ack_cnt[0];
    for (int i = 0; i < 3; i++) begin
      load(0, 8'(8'h10 + i), 1'b0);
      expect_tx(0, 8'(8'h10 + i));
    end
    drive_sources();
    wait_drain("abort_drain", 100);
    check("abort_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("abort_ack_count", 32'(ack_cnt[0] - ack0), 32'd3);
    // rr_ptr is now 1, so source 1 goes before source 0.
    load(0, 8'hE0, 1'b1);
    load(1, 8'hE1, 1'b1);
    expect_tx(1, 8'hE1);
    expect_tx(0, 8'hE0);
    drive_sources();
    tick();
    check("abort_next_grant", 32'(grant), 32'h2);
    wait_drain("abort_next_drain", 60);

    // UART never raises busy after a start.
    tx_mute = 1'b1;
    fd0 = fd_cnt;
    load(2, 8'h99, 1'b1);
    expect_tx(2, 8'h99);
    drive_sources();
    wait_start("stall_start", 10);
`ifdef VLC_TX_ARB_WDOG_EN
    n = 0;
    while ((err_cnt == 0) && (n < 200)) begin
      tick();
      n++;
    end
    check("wdog_latency", 32'(err_cyc - start_cyc), 32'(WDOG_CYCLES));
    check("wdog_frame_done", 32'(fd_cyc), 32'(err_cyc));
    check("wdog_grant", 32'(grant), 32'd0);
    tx_mute = 1'b0;
    tick();
`else
    repeat (150) tick();
    check("stall_grant_held", 32'(grant), 32'h4);
    check("stall_no_release", 32'(fd_cnt - fd0), 32'd0);
    check("stall_no_err", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_mute = 1'b0;
    check("stall_reset_grant", 32'(grant), 32'd0);
`endif

    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
`ifdef VLC_TX_ARB_WDOG_EN
    check("err_total", 32'(err_cnt), 32'd1);
`else
    check("err_total", 32'(err_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vlc_tx_arbiter.md
Name: vlc_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter between NUM_REQ frame sources (e.g. link-control, payload, loopback-test).
- Grants are round-robin per frame: a granted source keeps the transmitter until it marks its last byte or hits the MAX_FRAME cap.
- Sits between the source FIFOs and the UART TX, and sequences the transmitter's start/busy handshake one byte at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- MAX_FRAME, 16, maximum bytes per grant before forced release (1..255).
- WDOG_CYCLES, 1024, watchdog limit in clocks (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-source request, held while the source has a byte ready.
- req_data  in  NUM_REQ*DATA_W  flat data; source i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  qualifies the presented byte as the last of its frame.
- req_ack  out  NUM_REQ  one-cycle pulse: byte consumed, source advances.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- tx_data  out  DATA_W  byte to the UART TX.
- tx_start  out  1  one-cycle start strobe to the UART TX.
- tx_busy  in  1  UART TX busy flag.
- frame_done  out  1  one-cycle pulse when a grant is released.
- err_timeout  out  1  one-cycle watchdog error pulse; constant 0 without the optional feature.

Behaviour:
- Reset: all outputs are registered, state=IDLE, rr_ptr=0 (highest priority to source 0), byte_cnt=0.
  - Values: grant=0, req_ack=0, tx_start=0, tx_data=0, frame_done=0, err_timeout=0.
  - Reset mid-frame aborts immediately. No ack or start is issued in the reset cycle.
- States: IDLE, SEND, WAIT_ACC, WAIT_DONE.
- IDLE:
  - If req is nonzero, select the first set bit searching from rr_ptr upward with wrap-around.
  - Set grant to that source's one-hot value, clear byte_cnt, go to SEND.
- SEND: when tx_busy=0, in a single cycle:
  - tx_start=1, tx_data=req_data[sel], req_ack[sel]=1.
  - Latch last_q=req_last[sel], increment byte_cnt, go to WAIT_ACC.
  - If req[sel]=0 on entry to SEND, release without sending (abort path below).
- WAIT_ACC: wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0, then:
  - If last_q=1 or byte_cnt==MAX_FRAME: release.
  - Else if req[sel]=1: go to SEND.
  - Else: abort release.
- Release and abort (identical actions):
  - grant=0, frame_done pulse, rr_ptr=(sel+1) mod NUM_REQ, go to IDLE.
- Latency:
  - req rising in IDLE at cycle N gives grant at N+1, and tx_start/req_ack at N+2 if tx_busy=0.
  - Between bytes: tx_busy falling at cycle M gives the next tx_start at M+2.
- Fairness:
  - New requests arriving during a frame never preempt the owner.
  - After release, the next arbitration takes one IDLE cycle.
- byte_cnt is 8 bits and saturates; it never wraps.
- tx_start is never asserted while tx_busy=1.
- Exactly one req_ack pulse per tx_start.
- grant is one-hot or zero at all times.

Optional Feature:
- Macro: VLC_TX_ARB_WDOG_EN.
- When defined: a counter runs in WAIT_ACC and WAIT_DONE and clears on each state entry.
  - On reaching WDOG_CYCLES-1, the block pulses err_timeout, releases the grant (frame_done also pulses), advances rr_ptr and returns to IDLE.
  - The same applies if tx_busy is stuck high or never rises.
- When undefined: no counter; err_timeout is tied to 0; the block waits indefinitely.

Test Plan:
- Reset, then idle with req=0.
  - All outputs 0 for 10 cycles.
  - Assert rst for 1 cycle in WAIT_DONE → grant=0 and state=IDLE on the next cycle.
- Source 1 sends a 2-byte frame 0xA5, 0x3C (last on the second byte); TX model busy for 5 cycles per byte.
  - grant=4'b0010.
  - Two tx_start pulses carrying 0xA5 then 0x3C; two req_ack[1] pulses.
  - frame_done after the second busy fall; grant=0.
- All four sources request continuously with 1-byte frames.
  - Grant order 0,1,2,3,0 with no source skipped or repeated.
- Source 2 never asserts last, with MAX_FRAME=16.
  - Exactly 16 tx_start pulses, then release to source 3 (if it is requesting).
- Source 0 drops req after 3 bytes without last.
  - Abort: frame_done pulse, no 4th tx_start, rr_ptr=1.
- With VLC_TX_ARB_WDOG_EN and WDOG_CYCLES=64, tx_busy held at 0 after tx_start.
  - err_timeout pulse 64 cycles after entering WAIT_ACC; grant cleared.
